// File: rtl/ahb_burst_master.sv
// ahb_burst_master: AHB-Lite initiator issuing one NONSEQ/SEQ burst per command.
// Define AHB_MST_ERR_ABORT_EN to abort the remaining beats on an ERROR response.
module ahb_burst_master #(
    parameter int LEN_W  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wd_data,
    output logic              wd_pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] Haddr,
    output logic [1:0]        Htrans,
    output logic              Hwrite,
    output logic [2:0]        Hsize,
    output logic [2:0]        Hburst,
    output logic [DATA_W-1:0] Hwdata,
    input  logic              Hreadyin,
    input  logic [DATA_W-1:0] Hrdata,
    input  logic [1:0]        Hresp
);
    typedef enum logic [2:0] {IDLE, ADDR, BURST, LAST, ABRT} state_t;
    localparam logic [1:0] TR_IDLE = 2'b00;
    localparam logic [1:0] TR_NSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ  = 2'b11;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_nx;
    logic [1:0]        trans_q, trans_d;
    logic              write_q, write_d;
    logic [2:0]        burst_q, burst_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              aph, dph, err_hit, unused_ok;

    // aph: an address phase is accepted; dph: a data phase completes
    assign aph     = (state_q == ADDR || state_q == BURST) && Hreadyin;
    assign dph     = (state_q == BURST || state_q == LAST) && Hreadyin;
    assign addr_nx = addr_q + ADDR_W'(4);
`ifdef AHB_MST_ERR_ABORT_EN
    assign err_hit = (state_q == BURST || state_q == LAST) && !Hreadyin && Hresp == 2'b01;
    assign err     = state_q == ABRT && Hreadyin;
`else
    assign err_hit = 1'b0;
    assign err     = 1'b0;
`endif
    assign unused_ok = ^{Hresp, cmd_addr[1:0]};

    assign cmd_ready = state_q == IDLE;
    assign wd_pop    = aph && write_q;
    assign rd_valid  = dph && !write_q;
    assign rd_data   = rd_valid ? Hrdata : '0;
    assign done      = (state_q == LAST || state_q == ABRT) && Hreadyin;
    assign Haddr     = addr_q;
    assign Htrans    = trans_q;
    assign Hwrite    = write_q;
    assign Hsize     = 3'b010;
    assign Hburst    = burst_q;
    assign Hwdata    = wdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        trans_d = trans_q;
        write_d = write_q;
        burst_d = burst_q;
        wdata_d = wd_pop ? wd_data : wdata_q;
        if (state_q == IDLE && cmd_valid) begin
            state_d = ADDR;
            cnt_d   = cmd_len;
            addr_d  = {cmd_addr[ADDR_W-1:2], 2'b00};
            trans_d = TR_NSEQ;
            write_d = cmd_write;
            burst_d = cmd_len == '0 ? 3'b000 : 3'b001;
        end else if (err_hit) begin
            state_d = ABRT;
            trans_d = TR_IDLE;
        end else if (aph) begin
            // a beat landing on a 1KB boundary restarts as NONSEQ
            state_d = cnt_q == '0 ? LAST : BURST;
            trans_d = cnt_q == '0 ? TR_IDLE : (addr_nx[9:0] == '0 ? TR_NSEQ : TR_SEQ);
            addr_d  = cnt_q == '0 ? addr_q : addr_nx;
            cnt_d   = cnt_q - LEN_W'(1);
        end else if (done) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            trans_q <= TR_IDLE;
            write_q <= 1'b0;
            burst_q <= 3'b000;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            trans_q <= trans_d;
            write_q <= write_d;
            burst_q <= burst_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: tb/tb_ahb_burst_master.sv
// tb_ahb_burst_master: directed bursts checked every cycle against a beat-list model,
// plus literal expectations taken from recorded traces.
`timescale 1ns/1ps
module tb_ahb_burst_master;
    logic        Hclk = 1'b0;
    logic        Hreset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic        Hreadyin = 1'b1;
    logic [1:0]  Hresp = 2'b00;
    logic [31:0] wd_data, rd_data, Haddr, Hwdata, Hrdata;
    logic        wd_pop, rd_valid, done, err, cmd_ready, Hwrite;
    logic [1:0]  Htrans;
    logic [2:0]  Hsize, Hburst;
    logic [31:0] wbase = '0;
    logic [31:0] wptr = '0;
    logic [31:0] s_addr = '0;
    int checks = 0, errors = 0;
    int n_rd = 0, n_pop = 0, n_done = 0, n_err = 0;
    int d_rd, d_pop, d_done, d_err;
    logic [1:0]  tr_trans [0:47];
    logic [31:0] tr_addr  [0:47];
    logic [31:0] tr_wdata [0:47];
    logic [2:0]  tr_burst [0:47];
    logic        tr_done  [0:47];
    logic        tr_err   [0:47];
    logic        tr_rdy   [0:47];
`ifdef AHB_MST_ERR_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    ahb_burst_master dut (
        .Hclk(Hclk), .Hreset(Hreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wd_data(wd_data),
        .wd_pop(wd_pop), .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
        .Haddr(Haddr), .Htrans(Htrans), .Hwrite(Hwrite), .Hsize(Hsize), .Hburst(Hburst),
        .Hwdata(Hwdata), .Hreadyin(Hreadyin), .Hrdata(Hrdata), .Hresp(Hresp)
    );

    initial forever #5 Hclk = ~Hclk;

    function automatic logic [31:0] rd_pat(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // write-data source advances on each pop; slave returns data derived from the accepted address
    assign wd_data = wbase ^ wptr;
    assign Hrdata  = rd_pat(s_addr);
    initial forever begin
        @(posedge Hclk);
        if (wd_pop) wptr <= wptr + 32'd1;
        if (Hreadyin && Htrans[1]) s_addr <= Haddr;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: current address beat, queue of remaining beats, and the data phase in flight
    logic        armed = 1'b0, m_busy = 1'b0, m_cv = 1'b0, m_dp = 1'b0, m_ab = 1'b0, m_w = 1'b0;
    logic [31:0] m_ca = '0, m_da = '0, m_hw = '0, a;
    logic [1:0]  m_ct = '0;
    logic [2:0]  m_b = '0;
    logic [33:0] m_aq [$];
    logic        e_done, e_rv;

    initial forever begin
        @(negedge Hclk);
        if (armed) begin
            e_done = m_busy && Hreadyin && (m_ab || (m_dp && !m_cv));
            e_rv   = m_dp && !m_w && Hreadyin && !m_ab;
            chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
            chk("Htrans", 32'(Htrans), 32'(m_cv ? m_ct : 2'b00));
            if (m_cv) chk("Haddr", Haddr, m_ca);
            if (m_busy) begin
                chk("Hwrite", 32'(Hwrite), 32'(m_w));
                chk("Hburst", 32'(Hburst), 32'(m_b));
            end
            chk("Hsize", 32'(Hsize), 32'h2);
            chk("Hwdata", Hwdata, m_hw);
            chk("wd_pop", 32'(wd_pop), 32'(m_cv && m_w && Hreadyin));
            chk("rd_valid", 32'(rd_valid), 32'(e_rv));
            if (e_rv) chk("rd_data", rd_data, rd_pat(m_da));
            chk("done", 32'(done), 32'(e_done));
            chk("err", 32'(err), 32'(e_done && m_ab));
            if (rd_valid) n_rd++;
            if (wd_pop) n_pop++;
            if (done) n_done++;
            if (err) n_err++;
        end
        if (Hreset) begin
            m_busy = 0; m_cv = 0; m_dp = 0; m_ab = 0; m_hw = '0; armed = 1;
            m_aq.delete();
        end else if (armed) begin
            if (!m_busy) begin
                if (cmd_valid) begin
                    m_aq.delete();
                    for (int i = 0; i <= int'(cmd_len); i++) begin
                        a = {cmd_addr[31:2], 2'b00} + 32'(4 * i);
                        m_aq.push_back({a, (i == 0 || a[9:0] == 10'd0) ? 2'b10 : 2'b11});
                    end
                    {m_ca, m_ct} = m_aq.pop_front();
                    m_cv = 1; m_busy = 1; m_w = cmd_write;
                    m_b = cmd_len == 4'd0 ? 3'b000 : 3'b001;
                end
            end else if (ABORT_EN && m_dp && !m_ab && !Hreadyin && Hresp == 2'b01) begin
                m_ab = 1; m_cv = 0;
                m_aq.delete();
            end else if (Hreadyin) begin
                if (e_done) begin
                    m_busy = 0; m_dp = 0; m_ab = 0;
                end else begin
                    m_dp = 1; m_da = m_ca;
                    if (m_w) m_hw = wd_data;
                    if (m_aq.size() > 0) {m_ca, m_ct} = m_aq.pop_front();
                    else m_cv = 0;
                end
            end
        end
    end

    task automatic step(input logic rdy, input logic [1:0] resp);
        @(posedge Hclk);
        #1;
        Hreadyin = rdy;
        Hresp = resp;
    endtask

    task automatic rec(input int i);
        @(negedge Hclk);
        tr_trans[i] = Htrans; tr_addr[i] = Haddr; tr_wdata[i] = Hwdata; tr_burst[i] = Hburst;
        tr_done[i] = done; tr_err[i] = err; tr_rdy[i] = cmd_ready;
    endtask

    // cycle 0 presents the command; cycles 1..n follow the ready/error masks, then 3 idle cycles
    task automatic run_cmd(input logic w, input logic [31:0] ad, input logic [3:0] len,
                           input logic [31:0] rdy, input logic [31:0] errm, input int n,
                           input logic hold, input int rst_at, input logic [31:0] wb);
        int r0, p0, dn0, e0;
        step(1'b1, 2'b00);
        r0 = n_rd; p0 = n_pop; dn0 = n_done; e0 = n_err;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = ad; cmd_len = len;
        wbase = wb ^ wptr;
        rec(0);
        for (int i = 1; i <= n; i++) begin
            step(i > 32 ? 1'b1 : rdy[i-1], (i <= 32 && errm[i-1]) ? 2'b01 : 2'b00);
            cmd_valid = hold;
            Hreset = (i == rst_at);
            rec(i);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b00);
            cmd_valid = 1'b0;
            Hreset = 1'b0;
        end
        d_rd = n_rd - r0; d_pop = n_pop - p0; d_done = n_done - dn0; d_err = n_err - e0;
    endtask

    initial begin
        repeat (3) @(posedge Hclk);
        #1 Hreset = 1'b0;
        @(negedge Hclk);
        chk("rst_Htrans", 32'(Htrans), 32'h0);
        chk("rst_Haddr", Haddr, 32'h0);
        chk("rst_Hwdata", Hwdata, 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_Hwrite", 32'(Hwrite), 32'h0);
        chk("rst_Hburst", 32'(Hburst), 32'h0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("rst_pulses", 32'({wd_pop, rd_valid, done, err}), 32'h0);

        run_cmd(1'b1, 32'h8000_0000, 4'd0, '1, '0, 4, 1'b0, 0, 32'hDEAD_BEEF);
        chk("t1_trans1", 32'(tr_trans[1]), 32'h2);
        chk("t1_addr1", tr_addr[1], 32'h8000_0000);
        chk("t1_burst", 32'(tr_burst[1]), 32'h0);
        chk("t1_wdata2", tr_wdata[2], 32'hDEAD_BEEF);
        chk("t1_done2", 32'(tr_done[2]), 32'h1);
        chk("t1_trans2", 32'(tr_trans[2]), 32'h0);
        chk("t1_pops", d_pop, 32'd1);

        run_cmd(1'b0, 32'h8400_0000, 4'd3, 32'hFFFF_FFF3, '0, 9, 1'b0, 0, '0);
        chk("t2_trans1", 32'(tr_trans[1]), 32'h2);
        chk("t2_addr2", tr_addr[2], 32'h8400_0004);
        chk("t2_trans2", 32'(tr_trans[2]), 32'h3);
        chk("t2_addr3", tr_addr[3], 32'h8400_0008);
        chk("t2_hold4", tr_addr[4], 32'h8400_0008);
        chk("t2_hold5", 32'(tr_trans[5]), 32'h3);
        chk("t2_addr6", tr_addr[6], 32'h8400_000C);
        chk("t2_done7", 32'(tr_done[7]), 32'h1);
        chk("t2_reads", d_rd, 32'd4);
        chk("t2_dones", d_done, 32'd1);

        run_cmd(1'b1, 32'h8000_03F8, 4'd3, '1, '0, 6, 1'b0, 0, 32'h1234_0000);
        chk("t3_burst", 32'(tr_burst[1]), 32'h1);
        chk("t3_trans", 32'({tr_trans[1], tr_trans[2], tr_trans[3], tr_trans[4]}), 32'hBB);
        chk("t3_addr3", tr_addr[3], 32'h8000_0400);
        chk("t3_addr4", tr_addr[4], 32'h8000_0404);
        chk("t3_done5", 32'(tr_done[5]), 32'h1);
        chk("t3_pops", d_pop, 32'd4);

        run_cmd(1'b1, 32'h9000_0000, 4'd7, '1, '0, 5, 1'b0, 2, 32'hC0DE_0000);
        chk("t4_trans3", 32'(tr_trans[3]), 32'h0);
        chk("t4_addr3", tr_addr[3], 32'h0);
        chk("t4_wdata3", tr_wdata[3], 32'h0);
        chk("t4_burst3", 32'(tr_burst[3]), 32'h0);
        chk("t4_ready3", 32'(tr_rdy[3]), 32'h1);
        chk("t4_dones", d_done, 32'd0);
        chk("t4_pops", d_pop, 32'd2);

        run_cmd(1'b0, 32'h8800_0000, 4'd3, 32'hFFFF_FFFD, 32'h6, 9, 1'b0, 0, '0);
`ifdef AHB_MST_ERR_ABORT_EN
        chk("t5_trans3", 32'(tr_trans[3]), 32'h0);
        chk("t5_done_err3", 32'({tr_done[3], tr_err[3]}), 32'h3);
        chk("t5_reads", d_rd, 32'd0);
        chk("t5_errs", d_err, 32'd1);
`else
        chk("t5_done6", 32'(tr_done[6]), 32'h1);
        chk("t5_reads", d_rd, 32'd4);
        chk("t5_errs", d_err, 32'd0);
`endif
        chk("t5_dones", d_done, 32'd1);

        run_cmd(1'b0, 32'h8C00_0010, 4'd0, '1, '0, 5, 1'b1, 0, '0);
        chk("t6_done2", 32'(tr_done[2]), 32'h1);
        chk("t6_busy2", 32'(tr_rdy[2]), 32'h0);
        chk("t6_idle3", 32'({tr_rdy[3], tr_trans[3]}), 32'h4);
        chk("t6_trans4", 32'(tr_trans[4]), 32'h2);
        chk("t6_dones", d_done, 32'd2);

        run_cmd(1'b0, 32'hFFFF_FFF0, 4'd15, 32'hB6DB_6DB6, '0, 40, 1'b0, 0, '0);
        chk("t7_addr1", tr_addr[1], 32'hFFFF_FFF0);
        chk("t7_reads", d_rd, 32'd16);
        chk("t7_dones", d_done, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
